// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex game judge.
package reflex_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StWindow,
    StJudged,
    StOver
  } state_e;

  localparam int unsigned MS_W    = 12;
  localparam int unsigned ROUND_W = 5;
  localparam int unsigned BTN_W   = 4;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  function automatic logic [BTN_W-1:0] onehot2(input logic [1:0] sel);
    return BTN_W'(1) << sel;
  endfunction

endpackage

// File: rtl/reflex_judge_if.sv
// Bundle of game-side signals between the judge and its surroundings.
interface reflex_judge_if;
  import reflex_pkg::*;

  logic             switch;
  logic             clk_5s;
  logic [BTN_W-1:0] btn;
  logic [BTN_W-1:0] prompt;
  logic [7:0]       score;
  logic [2:0]       wrong_time;
  logic             hit;
  logic             miss;
  logic [MS_W-1:0]  last_ms;
  logic [MS_W-1:0]  best_ms;
  logic             game_over;

  modport master (
    output switch, clk_5s, btn,
    input  prompt, score, wrong_time, hit, miss, last_ms, best_ms, game_over
  );

  modport slave (
    input  switch, clk_5s, btn,
    output prompt, score, wrong_time, hit, miss, last_ms, best_ms, game_over
  );

endinterface

// File: rtl/reflex_btn_sync.sv
// Two-flop synchronizer plus rising-edge detect for the asynchronous player buttons.
module reflex_btn_sync
  import reflex_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] i_btn,
  output logic [BTN_W-1:0] o_rise
);

  logic [BTN_W-1:0] r_sync1;
  logic [BTN_W-1:0] r_sync2;
  logic [BTN_W-1:0] r_sync2_q;

  // Synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync2_q <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_sync2_q <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_sync2_q;

endmodule

// File: rtl/reflex_judge.sv
// Round judge: opens a prompt window on each round tick and scores the player's response.
module reflex_judge
  import reflex_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ROUNDS    = 30,
  parameter int unsigned MAX_WRONG = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic          clk,
  input logic          rst_n,
  reflex_judge_if.slave bus
);

  localparam int unsigned PRESC   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(PRESC - 1);
  localparam logic [ROUND_W-1:0] ROUNDS_C    = ROUND_W'(ROUNDS);
  localparam logic [2:0]         MAX_WRONG_C = 3'(MAX_WRONG);

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_lfsr, w_lfsr_nxt;
  logic             r_clk5s_q;
  logic [ROUND_W-1:0] r_round, w_round_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic [MS_W-1:0]  r_ms, w_ms_nxt;
  logic [BTN_W-1:0] r_prompt, w_prompt_nxt;
  logic [7:0]       r_score, w_score_nxt;
  logic [2:0]       r_wrong, w_wrong_nxt;
  logic             r_hit, w_hit_nxt;
  logic             r_miss, w_miss_nxt;
  logic [MS_W-1:0]  r_last_ms, w_last_ms_nxt;
  logic [MS_W-1:0]  r_best_ms, w_best_ms_nxt;
  logic             r_game_over, w_game_over_nxt;

  logic [BTN_W-1:0] w_rise;
  logic             w_tick;
  logic             w_press;
  logic             w_start;
  logic             w_end;

  reflex_btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_btn (bus.btn),
    .o_rise(w_rise)
  );

  assign w_tick  = bus.clk_5s ^ r_clk5s_q;
  assign w_press = |w_rise;

  // Next-state, scoring and round bookkeeping; everything holds while switch is low.
  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_nxt      = r_lfsr;
    w_round_nxt     = r_round;
    w_presc_nxt     = r_presc;
    w_ms_nxt        = r_ms;
    w_prompt_nxt    = r_prompt;
    w_score_nxt     = r_score;
    w_wrong_nxt     = r_wrong;
    w_hit_nxt       = 1'b0;
    w_miss_nxt      = 1'b0;
    w_last_ms_nxt   = r_last_ms;
    w_best_ms_nxt   = r_best_ms;
    w_game_over_nxt = r_game_over;
    w_start         = 1'b0;
    w_end           = 1'b0;

    if (bus.switch) begin
      w_lfsr_nxt = lfsr_next(r_lfsr);

      case (r_state)
        StIdle:  w_state_nxt = StArmed;
        StArmed: w_start = w_tick;
        StWindow: begin
          if (r_presc == PRESC_MAX) begin
            w_presc_nxt = '0;
            if (r_ms != {MS_W{1'b1}}) w_ms_nxt = r_ms + MS_W'(1);
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
          // A tick wins over a simultaneous press: the round is lost and the next one opens.
          if (w_tick) begin
            w_miss_nxt = 1'b1;
            if (r_round >= ROUNDS_C) w_end = 1'b1;
            else                     w_start = 1'b1;
          end else if (w_press) begin
            w_state_nxt  = StJudged;
            w_prompt_nxt = '0;
            if (w_rise == r_prompt) begin
              w_hit_nxt     = 1'b1;
              w_last_ms_nxt = r_ms;
              if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
              if (r_ms < r_best_ms) w_best_ms_nxt = r_ms;
            end else begin
              w_miss_nxt = 1'b1;
            end
          end
        end
        StJudged: begin
          if (w_tick) begin
            if (r_round >= ROUNDS_C) w_end = 1'b1;
            else                     w_start = 1'b1;
          end
        end
        default: ;
      endcase

      if (w_miss_nxt) begin
        if (r_wrong != 3'd7) w_wrong_nxt = r_wrong + 3'd1;
        if (w_wrong_nxt >= MAX_WRONG_C) w_end = 1'b1;
      end

      if (w_end) begin
        w_state_nxt     = StOver;
        w_prompt_nxt    = '0;
        w_game_over_nxt = 1'b1;
      end else if (w_start) begin
        w_state_nxt  = StWindow;
        w_prompt_nxt = onehot2(r_lfsr[1:0]);
        w_round_nxt  = r_round + ROUND_W'(1);
        w_ms_nxt     = '0;
        w_presc_nxt  = '0;
      end
    end
  end

  // State registers; the tick reference follows clk_5s even while paused so stale edges vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_lfsr      <= LFSR_SEED;
      r_clk5s_q   <= 1'b0;
      r_round     <= '0;
      r_presc     <= '0;
      r_ms        <= '0;
      r_prompt    <= '0;
      r_score     <= '0;
      r_wrong     <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_last_ms   <= '0;
      r_best_ms   <= {MS_W{1'b1}};
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_clk5s_q   <= bus.clk_5s;
      r_round     <= w_round_nxt;
      r_presc     <= w_presc_nxt;
      r_ms        <= w_ms_nxt;
      r_prompt    <= w_prompt_nxt;
      r_score     <= w_score_nxt;
      r_wrong     <= w_wrong_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_last_ms   <= w_last_ms_nxt;
      r_best_ms   <= w_best_ms_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign bus.prompt     = r_prompt;
  assign bus.score      = r_score;
  assign bus.wrong_time = r_wrong;
  assign bus.hit        = r_hit;
  assign bus.miss       = r_miss;
  assign bus.last_ms    = r_last_ms;
  assign bus.best_ms    = r_best_ms;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_reflex_judge.sv
// Directed bench for reflex_judge at CLK_HZ=1000 (one ms per clock).
module tb_reflex_judge;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [15:0] m_lfsr;

  reflex_judge_if bus ();

  reflex_judge #(
    .CLK_HZ   (1000),
    .ROUNDS   (30),
    .MAX_WRONG(3),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting, runs while switch is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else if (bus.switch) m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.switch = 1'b0;
    bus.clk_5s = 1'b0;
    bus.btn    = '0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic start_game();
    do_reset();
    bus.switch = 1'b1;
    idle(2);
  endtask

  // Toggle the round tick now; exp is the prompt the judge must show one cycle later.
  task automatic tick(output logic [3:0] exp);
    exp        = 4'b0001 << m_lfsr[1:0];
    bus.clk_5s = ~bus.clk_5s;
    idle(1);
  endtask

  // Raise btn and wait (bounded) for a hit/miss pulse; lat=0 means none arrived.
  task automatic press(input logic [3:0] v, output int lat, output logic h, output logic m);
    bus.btn = v;
    lat = 0;
    h   = 1'b0;
    m   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.hit || bus.miss) begin
        lat = i;
        h   = bus.hit;
        m   = bus.miss;
        break;
      end
    end
    bus.btn = '0;
  endtask

  task automatic test_reset();
    logic [47:0] got;
    do_reset();
    got = {bus.prompt, bus.score, 1'b0, bus.wrong_time, 2'b00, bus.hit, bus.miss,
           bus.last_ms, bus.best_ms, 3'b000, bus.game_over};
    n_vec++;
    if (got !== 48'h0_00_0_0_000_FFF_0) begin
      n_err++;
      $display("FAIL reset_values: got %h want %h", got, 48'h0_00_0_0_000_FFF_0);
    end
  endtask

  task automatic test_hit();
    logic [3:0] exp;
    int lat;
    logic h, m;
    start_game();
    tick(exp);
    n_vec++;
    if (bus.prompt !== exp) begin n_err++; $display("FAIL hit_prompt: got %b want %b", bus.prompt, exp); end
    idle(9);
    press(exp, lat, h, m);
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL hit_latency: got %0d want 3", lat); end
    n_vec++;
    if ({h, m} !== 2'b10) begin n_err++; $display("FAIL hit_pulse: got %b want 10", {h, m}); end
    n_vec++;
    if (bus.score !== 8'd1) begin n_err++; $display("FAIL hit_score: got %0d want 1", bus.score); end
    n_vec++;
    if (bus.last_ms < 12'd7 || bus.last_ms > 12'd13) begin
      n_err++; $display("FAIL hit_last_ms: got %0d want 7..13", bus.last_ms);
    end
    n_vec++;
    if (bus.best_ms !== 12'd11) begin n_err++; $display("FAIL hit_best_ms: got %0d want 11", bus.best_ms); end
  endtask

  task automatic test_wrong_then_right();
    logic [3:0] exp;
    int lat;
    logic h, m;
    start_game();
    tick(exp);
    idle(2);
    press({exp[2:0], exp[3]}, lat, h, m);
    n_vec++;
    if ({lat, h, m} !== {32'd3, 2'b01}) begin
      n_err++; $display("FAIL wrong_press: got lat=%0d h=%b m=%b want lat=3 h=0 m=1", lat, h, m);
    end
    n_vec++;
    if (bus.wrong_time !== 3'd1) begin n_err++; $display("FAIL wrong_count: got %0d want 1", bus.wrong_time); end
    n_vec++;
    if (bus.prompt !== 4'd0) begin n_err++; $display("FAIL wrong_prompt_clear: got %b want 0000", bus.prompt); end
    idle(3);
    press(exp, lat, h, m);
    n_vec++;
    if (lat !== 0) begin n_err++; $display("FAIL second_press_ignored: got pulse at %0d want none", lat); end
    n_vec++;
    if ({bus.score, bus.wrong_time} !== {8'd0, 3'd1}) begin
      n_err++; $display("FAIL wrong_totals: got score=%0d wrong=%0d want 0/1", bus.score, bus.wrong_time);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    start_game();
    tick(exp);
    for (int k = 1; k <= 3; k++) begin
      idle(3);
      tick(exp);
      n_vec++;
      if ({bus.miss, bus.hit, bus.wrong_time} !== {2'b10, 3'(k)}) begin
        n_err++;
        $display("FAIL timeout_%0d: got miss=%b hit=%b wrong=%0d want 1/0/%0d",
                 k, bus.miss, bus.hit, bus.wrong_time, k);
      end
      n_vec++;
      if (bus.game_over !== (k == 3)) begin
        n_err++; $display("FAIL timeout_over_%0d: got %b want %b", k, bus.game_over, k == 3);
      end
      n_vec++;
      if (bus.prompt !== ((k == 3) ? 4'd0 : exp)) begin
        n_err++; $display("FAIL timeout_prompt_%0d: got %b want %b", k, bus.prompt, (k == 3) ? 4'd0 : exp);
      end
    end
    idle(2);
    tick(exp);
    n_vec++;
    if ({bus.miss, bus.wrong_time, bus.prompt} !== {1'b0, 3'd3, 4'd0}) begin
      n_err++; $display("FAIL over_sticky: got miss=%b wrong=%0d prompt=%b want 0/3/0000",
                        bus.miss, bus.wrong_time, bus.prompt);
    end
  endtask

  task automatic test_double_press();
    logic [3:0] exp;
    int lat;
    logic h, m;
    start_game();
    tick(exp);
    idle(2);
    press(4'b0011, lat, h, m);
    n_vec++;
    if ({h, m, bus.wrong_time} !== {2'b01, 3'd1}) begin
      n_err++; $display("FAIL double_press: got h=%b m=%b wrong=%0d want 0/1/1", h, m, bus.wrong_time);
    end
  endtask

  task automatic test_coincident();
    logic [3:0] exp, exp2;
    start_game();
    tick(exp);
    idle(4);
    bus.btn = exp;
    idle(2);
    tick(exp2);
    n_vec++;
    if ({bus.hit, bus.miss, bus.score, bus.wrong_time} !== {2'b01, 8'd0, 3'd1}) begin
      n_err++; $display("FAIL coincident: got hit=%b miss=%b score=%0d wrong=%0d want 0/1/0/1",
                        bus.hit, bus.miss, bus.score, bus.wrong_time);
    end
    n_vec++;
    if (bus.prompt !== exp2) begin n_err++; $display("FAIL coincident_prompt: got %b want %b", bus.prompt, exp2); end
    bus.btn = '0;
    idle(4);
    n_vec++;
    if ({bus.score, bus.wrong_time} !== {8'd0, 3'd1}) begin
      n_err++; $display("FAIL coincident_late: got score=%0d wrong=%0d want 0/1", bus.score, bus.wrong_time);
    end
  endtask

  task automatic test_freeze();
    logic [3:0] exp;
    int lat;
    logic h, m;
    start_game();
    tick(exp);
    idle(2);
    bus.switch = 1'b0;
    idle(1);
    bus.clk_5s = ~bus.clk_5s;
    idle(4);
    bus.switch = 1'b1;
    idle(3);
    n_vec++;
    if ({bus.wrong_time, bus.prompt} !== {3'd0, exp}) begin
      n_err++; $display("FAIL freeze_hold: got wrong=%0d prompt=%b want 0/%b", bus.wrong_time, bus.prompt, exp);
    end
    press(exp, lat, h, m);
    n_vec++;
    if ({h, bus.score} !== {1'b1, 8'd1}) begin
      n_err++; $display("FAIL freeze_resume_hit: got h=%b score=%0d want 1/1", h, bus.score);
    end
    tick(exp);
    n_vec++;
    if (bus.prompt !== exp) begin n_err++; $display("FAIL freeze_lfsr: got %b want %b", bus.prompt, exp); end
  endtask

  task automatic test_full_game();
    logic [3:0] exp;
    int lat;
    logic h, m;
    logic [47:0] got;
    start_game();
    for (int r = 1; r <= 30; r++) begin
      tick(exp);
      n_vec++;
      if (bus.prompt !== exp) begin n_err++; $display("FAIL round_%0d_prompt: got %b want %b", r, bus.prompt, exp); end
      idle(2);
      press(exp, lat, h, m);
      n_vec++;
      if (h !== 1'b1) begin n_err++; $display("FAIL round_%0d_hit: got %b want 1", r, h); end
    end
    n_vec++;
    if ({bus.score, bus.game_over, bus.last_ms, bus.best_ms} !== {8'd30, 1'b0, 12'd4, 12'd4}) begin
      n_err++; $display("FAIL full_totals: got score=%0d over=%b last=%0d best=%0d want 30/0/4/4",
                        bus.score, bus.game_over, bus.last_ms, bus.best_ms);
    end
    tick(exp);
    n_vec++;
    if ({bus.game_over, bus.prompt, bus.miss} !== {1'b1, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL full_end: got over=%b prompt=%b miss=%b want 1/0000/0",
                        bus.game_over, bus.prompt, bus.miss);
    end
    // Asynchronous reset in the middle of a live round.
    start_game();
    tick(exp);
    idle(3);
    #3;
    rst_n = 1'b0;
    #1;
    got = {bus.prompt, bus.score, 1'b0, bus.wrong_time, 2'b00, bus.hit, bus.miss,
           bus.last_ms, bus.best_ms, 3'b000, bus.game_over};
    n_vec++;
    if (got !== 48'h0_00_0_0_000_FFF_0) begin
      n_err++; $display("FAIL midround_reset: got %h want %h", got, 48'h0_00_0_0_000_FFF_0);
    end
    do_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.switch = 1'b0;
    bus.clk_5s = 1'b0;
    bus.btn    = '0;
    test_reset();
    test_hit();
    test_wrong_then_right();
    test_timeout();
    test_double_press();
    test_coincident();
    test_freeze();
    test_full_game();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
